// File: rtl/ts_pkg.sv
// Shared MPEG-TS constants and FSM encoding for the packet transmitter.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_PKT_LEN   = 188;
  localparam logic [12:0] NULL_PID     = 13'h1FFF;
  localparam logic [7:0]  STUFF_BYTE   = 8'hFF;
  // Null header byte 3: payload only, continuity counter 0.
  localparam logic [7:0]  NULL_AFC_CC  = 8'h10;

  typedef enum logic [1:0] {
    ST_BOUND = 2'd0,
    ST_DATA  = 2'd1,
    ST_NULLP = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_null_gen.sv
// Null-packet byte generator: maps a packet offset to the null packet byte.
module ts_null_gen
  import ts_pkg::*;
#(
  parameter int OFF_W = 8
) (
  input  logic [OFF_W-1:0] i_offset,
  output logic [7:0]       o_byte
);

  always_comb begin
    o_byte = STUFF_BYTE;
    case (i_offset)
      OFF_W'(0): o_byte = TS_SYNC_BYTE;
      OFF_W'(1): o_byte = {3'b000, NULL_PID[12:8]};
      OFF_W'(2): o_byte = NULL_PID[7:0];
      OFF_W'(3): o_byte = NULL_AFC_CC;
      default:   o_byte = STUFF_BYTE;
    endcase
  end

endmodule

// File: rtl/ts_packet_tx.sv
// TS packet transmitter: forwards upstream packets on byte ticks, stuffing
// null packets between them and counting framing errors.
module ts_packet_tx
  import ts_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int         PKT_LEN   = TS_PKT_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        sop_in,
  output logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        valid,
  output logic        sync,
  output logic [15:0] null_cnt,
  output logic [7:0]  err_cnt
);

  localparam int               OFF_W    = $clog2(PKT_LEN);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PKT_LEN - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  ts_state_e        r_state;
  ts_state_e        w_state_nxt;
  logic [OFF_W-1:0] r_offset;
  logic [OFF_W-1:0] w_offset_nxt;

  logic [7:0]  w_null_byte;
  logic [7:0]  w_byte_nxt;
  logic        w_sync_nxt;
  logic        w_err_inc;
  logic        w_null_inc;

  logic [7:0]  r_byte_p1;
  logic        r_vld_p1;
  logic        r_sync_p1;
  logic [15:0] r_null_cnt;
  logic [7:0]  r_err_cnt;

  ts_null_gen #(
    .OFF_W (OFF_W)
  ) u_null_gen (
    .i_offset (r_offset),
    .o_byte   (w_null_byte)
  );

  assign byte_ready = tick && (r_state != ST_NULLP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_BOUND;
      r_offset <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_offset <= w_offset_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    if (tick) begin
      case (r_state)
        ST_BOUND: begin
          w_offset_nxt = OFF_W'(1);
          w_state_nxt  = (byte_valid && sop_in) ? ST_DATA : ST_NULLP;
        end
        ST_DATA, ST_NULLP: begin
          if (r_offset == LAST_OFF) begin
            w_state_nxt  = ST_BOUND;
            w_offset_nxt = '0;
          end else begin
            w_offset_nxt = r_offset + 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_BOUND;
          w_offset_nxt = '0;
        end
      endcase
    end
  end

  // Byte selection and error/null events for the current slot; gated by tick below.
  always_comb begin
    w_byte_nxt = w_null_byte;
    w_sync_nxt = 1'b0;
    w_err_inc  = 1'b0;
    w_null_inc = 1'b0;
    case (r_state)
      ST_BOUND: begin
        w_sync_nxt = 1'b1;
        if (byte_valid && sop_in) begin
          w_byte_nxt = SYNC_BYTE;
          w_err_inc  = (byte_in != SYNC_BYTE);
        end else begin
          w_null_inc = 1'b1;
          w_err_inc  = byte_valid;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          w_byte_nxt = byte_in;
          w_err_inc  = sop_in;
        end else begin
          w_byte_nxt = STUFF_BYTE;
          w_err_inc  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered output byte, qualifiers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_p1  <= '0;
      r_vld_p1   <= 1'b0;
      r_sync_p1  <= 1'b0;
      r_null_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_vld_p1  <= tick;
      r_sync_p1 <= tick && w_sync_nxt;
      if (tick) begin
        r_byte_p1 <= w_byte_nxt;
        if (w_null_inc) r_null_cnt <= sat_inc16(r_null_cnt);
        if (w_err_inc)  r_err_cnt  <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign byte_out = r_byte_p1;
  assign valid    = r_vld_p1;
  assign sync     = r_sync_p1;
  assign null_cnt = r_null_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ts_packet_tx.sv
// Directed and randomized bench for ts_packet_tx against a packet-level reference model.
module tb_ts_packet_tx;

  localparam int PKT_LEN = 188;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        sop_in = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_out;
  logic        valid;
  logic        sync;
  logic [15:0] null_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  ts_packet_tx #(
    .SYNC_BYTE (8'h47),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .sop_in     (sop_in),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .valid      (valid),
    .sync       (sync),
    .null_cnt   (null_cnt),
    .err_cnt    (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the outgoing packet and what kind it is.
  logic [7:0] null_pkt [PKT_LEN];
  int         m_pos;
  bit         m_null;
  int         m_nulls;
  int         m_errs;
  logic [7:0] m_byte;
  bit         m_sync;
  bit         m_valid;
  bit         m_ready;
  int         since_sync;
  int         last_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_null = 0; m_nulls = 0; m_errs = 0;
    m_byte = 8'h00; m_sync = 0; m_valid = 0;
    since_sync = 0; last_gap = 0;
  endtask

  task automatic bump_err();
    if (m_errs < 255) m_errs++;
  endtask

  task automatic model_step(input bit t, input bit bv, input bit sop, input logic [7:0] b);
    m_ready = t && !(m_pos != 0 && m_null);
    m_valid = t;
    m_sync  = 0;
    if (!t) return;
    if (m_pos == 0) begin
      m_sync = 1;
      if (bv && sop) begin
        m_null = 0;
        m_byte = 8'h47;
        if (b != 8'h47) bump_err();
      end else begin
        m_null = 1;
        m_byte = null_pkt[0];
        if (m_nulls < 65535) m_nulls++;
        if (bv) bump_err();
      end
    end else if (m_null) begin
      m_byte = null_pkt[m_pos];
    end else if (bv) begin
      m_byte = b;
      if (sop) bump_err();
    end else begin
      m_byte = 8'hFF;
      bump_err();
    end
    m_pos = (m_pos + 1) % PKT_LEN;
  endtask

  // Called at a negedge; drives one cycle and checks the registered result.
  task automatic step(input bit t, input bit bv, input bit sop, input logic [7:0] b);
    tick = t; byte_valid = bv; sop_in = sop; byte_in = b;
    model_step(t, bv, sop, b);
    #1;
    check("byte_ready", byte_ready, m_ready);
    @(posedge clk);
    @(negedge clk);
    check("valid", valid, m_valid);
    check("sync", sync, m_sync);
    if (m_valid) check("byte_out", byte_out, m_byte);
    check("null_cnt", null_cnt, m_nulls);
    check("err_cnt", err_cnt, m_errs);
    if (valid) begin
      if (sync) begin
        last_gap   = since_sync;
        since_sync = 1;
      end else begin
        since_sync++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; tick = 1; byte_valid = 1; sop_in = 1; byte_in = 8'h47;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_over_tick_valid", valid, 0);
    rst = 0; tick = 0; byte_valid = 0; sop_in = 0; byte_in = 8'h00;
    model_reset();
    #1;
    check("reset_byte_out", byte_out, 0);
    check("reset_valid", valid, 0);
    check("reset_sync", sync, 0);
    check("reset_null_cnt", null_cnt, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_ready_idle", byte_ready, 0);
    @(negedge clk);
  endtask

  // Sends nbytes of a packet; bytes are held until a tick transfers them.
  task automatic send_pkt(input logic [7:0] b0, input int drop_lo, input int drop_hi,
                          input bit gaps, input int nbytes);
    logic [7:0] pkt [PKT_LEN];
    int i;
    bit t;
    pkt[0] = b0;
    for (int k = 1; k < PKT_LEN; k++) pkt[k] = 8'($urandom);
    i = 0;
    while (i < nbytes) begin
      t = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(t, !(i >= drop_lo && i <= drop_hi), i == 0, pkt[i]);
      if (t) i++;
    end
  endtask

  task automatic null_ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < PKT_LEN; k++) null_pkt[k] = 8'hFF;
    null_pkt[0] = 8'h47; null_pkt[1] = 8'h1F; null_pkt[2] = 8'hFF; null_pkt[3] = 8'h10;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle start: null packet header bytes
    null_ticks(3);
    check("first_null_cnt", null_cnt, 1);
    null_ticks(PKT_LEN - 3);

    // Clean packet with idle gaps between ticks
    send_pkt(8'h47, -1, -1, 1'b1, PKT_LEN);
    check("clean_pkt_err", err_cnt, 0);

    // Bad byte 0 is replaced by the sync byte
    send_pkt(8'h00, -1, -1, 1'b0, PKT_LEN);
    check("bad_sync_err", err_cnt, 1);

    // Underrun at offsets 50..52
    send_pkt(8'h47, 50, 52, 1'b0, PKT_LEN);
    check("underrun_err", err_cnt, 4);
    send_pkt(8'h47, -1, -1, 1'b0, PKT_LEN);
    check("sync_gap_after_underrun", last_gap, PKT_LEN);

    // Reset mid-packet, then idle and a fresh packet
    send_pkt(8'h47, -1, -1, 1'b0, 100);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    send_pkt(8'h47, -1, -1, 1'b1, PKT_LEN);

    // Drive err_cnt to saturation, then a long run of null insertion
    send_pkt(8'h00, 1, PKT_LEN - 1, 1'b0, PKT_LEN);
    send_pkt(8'h00, 1, PKT_LEN - 1, 1'b0, PKT_LEN);
    check("err_saturated", err_cnt, 255);
    null_ticks(300);
    check("null_sync_gap", last_gap, PKT_LEN);
    check("err_still_saturated", err_cnt, 255);

    // Random traffic
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
